// File: rtl/lagarto_dcache_req_queue.sv
// In-order CPU request queue feeding the L1 D-cache split load/store channels.
// Define LAGARTO_DCACHE_NACK_RETRY_EN to replay NACKed requests up to MAX_RETRY times.
module lagarto_dcache_req_queue #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned INDEX_W   = 12,
    parameter int unsigned TAG_W     = 28,
    parameter int unsigned ID_W      = 6,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cpu_req_valid_i,
    output logic                       cpu_req_ready_o,
    input  logic                       cpu_req_we_i,
    input  logic [INDEX_W+TAG_W-1:0]   cpu_req_addr_i,
    input  logic [DATA_W-1:0]          cpu_req_wdata_i,
    input  logic [1:0]                 cpu_req_size_i,
    input  logic                       cpu_req_signed_i,
    input  logic [ID_W-1:0]            cpu_req_id_i,
    input  logic                       cpu_kill_i,
    output logic                       ld_req_valid_o,
    input  logic                       ld_req_ready_i,
    output logic [INDEX_W-1:0]         ld_req_index_o,
    output logic [TAG_W-1:0]           ld_req_tag_o,
    output logic                       ld_req_tag_valid_o,
    output logic                       ld_req_kill_o,
    output logic [1:0]                 ld_req_size_o,
    output logic [DATA_W/8-1:0]        ld_req_be_o,
    output logic                       st_req_valid_o,
    input  logic                       st_req_ready_i,
    output logic [INDEX_W-1:0]         st_req_index_o,
    output logic [TAG_W-1:0]           st_req_tag_o,
    output logic                       st_req_tag_valid_o,
    output logic                       st_req_kill_o,
    output logic [1:0]                 st_req_size_o,
    output logic [DATA_W/8-1:0]        st_req_be_o,
    output logic [DATA_W-1:0]          st_req_wdata_o,
    input  logic                       ld_resp_valid_i,
    input  logic [DATA_W-1:0]          ld_resp_data_i,
    input  logic                       ld_resp_nack_i,
    input  logic                       st_resp_valid_i,
    input  logic                       st_resp_nack_i,
    output logic                       cpu_resp_valid_o,
    output logic [ID_W-1:0]            cpu_resp_id_o,
    output logic [DATA_W-1:0]          cpu_resp_data_o,
    output logic                       cpu_resp_err_o,
    output logic                       cpu_resp_store_o
);
    localparam int unsigned ADDR_W  = INDEX_W + TAG_W;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned OFF_W   = $clog2(BE_W);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned DIDX_W  = $clog2(DATA_W);
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_TAG   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    typedef struct packed {
        logic              we;
        logic              sgn;
        logic              err;
        logic [1:0]        size;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             hd;
    entry_t             entry_in;
    logic [PTR_W:0]     wr_ptr, rd_ptr;
    logic [2:0]         state, state_nxt;
    logic               full, empty, push, pop;
    logic               misalign, issue_v, req_ready, resp_v, resp_nack;
    logic               rsp_fire, rsp_err;
    logic               retry_left;
    logic [RETRY_W-1:0] retry_cnt;
    logic [OFF_W-1:0]   off;
    logic [BE_W-1:0]    be_mask, be;
    logic [DATA_W-1:0]  sh, ld_data;
    logic [31:0]        nbits;
    logic [DIDX_W-1:0]  msb;

    assign full            = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty           = (wr_ptr == rd_ptr);
    assign cpu_req_ready_o = !full;
    assign push            = cpu_req_valid_i && !full && !cpu_kill_i;
    assign hd              = mem[rd_ptr[PTR_W-1:0]];
    assign off             = hd.addr[OFF_W-1:0];
    assign req_ready       = hd.we ? st_req_ready_i  : ld_req_ready_i;
    assign resp_v          = hd.we ? st_resp_valid_i : ld_resp_valid_i;
    assign resp_nack       = hd.we ? st_resp_nack_i  : ld_resp_nack_i;
    assign issue_v         = (state == ST_ISSUE) && !hd.err && !cpu_kill_i;

    // Double-word accesses are also flagged when the bus is narrower than 64 bits.
    always_comb begin
        misalign = 1'b0;
        unique case (cpu_req_size_i)
            2'd0: misalign = 1'b0;
            2'd1: misalign = cpu_req_addr_i[0];
            2'd2: misalign = |cpu_req_addr_i[1:0];
            2'd3: misalign = (|cpu_req_addr_i[2:0]) || (DATA_W < 64);
            default: misalign = 1'b1;
        endcase
        entry_in = '{we: cpu_req_we_i, sgn: cpu_req_signed_i, err: misalign, size: cpu_req_size_i,
                     id: cpu_req_id_i, addr: cpu_req_addr_i, wdata: cpu_req_wdata_i};
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= entry_in;
    end

    // Byte enables and load-result alignment/extension for the head entry.
    always_comb begin
        nbits = 32'd8 << hd.size;
        msb   = (nbits > DATA_W) ? DIDX_W'(DATA_W - 1) : DIDX_W'(nbits - 32'd1);
        sh    = ld_resp_data_i >> {off, 3'b000};
        for (int i = 0; i < BE_W; i++) be_mask[i] = (32'(i) < (32'd1 << hd.size));
        be = be_mask << off;
        for (int i = 0; i < DATA_W; i++) ld_data[i] = (32'(i) < nbits) ? sh[i] : (hd.sgn & sh[msb]);
    end

`ifdef LAGARTO_DCACHE_NACK_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                                   retry_cnt <= '0;
        else if (cpu_kill_i || pop)                                  retry_cnt <= '0;
        else if (state == ST_WAIT && resp_v && resp_nack && retry_left) retry_cnt <= retry_cnt + RETRY_W'(1);
    end
`else
    localparam logic RETRY_EN = 1'b0;
    assign retry_cnt = '0;
`endif
    assign retry_left = RETRY_EN && (retry_cnt != RETRY_W'(MAX_RETRY));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        rsp_fire  = 1'b0;
        rsp_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!cpu_kill_i && (!empty || push)) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cpu_kill_i) state_nxt = ST_IDLE;
                else if (hd.err) begin
                    rsp_fire  = 1'b1;
                    rsp_err   = 1'b1;
                    pop       = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (req_ready) state_nxt = ST_TAG;
            end
            ST_TAG: state_nxt = cpu_kill_i ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                // A response landing in the kill cycle leaves nothing to drain.
                if (cpu_kill_i) state_nxt = resp_v ? ST_IDLE : ST_DRAIN;
                else if (resp_v) begin
                    if (resp_nack && retry_left) state_nxt = ST_ISSUE;
                    else begin
                        rsp_fire  = 1'b1;
                        rsp_err   = resp_nack;
                        pop       = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (ld_resp_valid_i || st_resp_valid_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (cpu_kill_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_resp_valid_o <= 1'b0;
            cpu_resp_id_o    <= '0;
            cpu_resp_data_o  <= '0;
            cpu_resp_err_o   <= 1'b0;
            cpu_resp_store_o <= 1'b0;
        end else begin
            cpu_resp_valid_o <= rsp_fire;
            cpu_resp_id_o    <= rsp_fire ? hd.id : '0;
            cpu_resp_data_o  <= (rsp_fire && !rsp_err && !hd.we) ? ld_data : '0;
            cpu_resp_err_o   <= rsp_fire && rsp_err;
            cpu_resp_store_o <= rsp_fire && hd.we;
        end
    end

    // Cache request channels: index phase in ISSUE, tag (or kill) phase in TAG.
    always_comb begin
        ld_req_valid_o     = 1'b0;
        ld_req_index_o     = '0;
        ld_req_tag_o       = '0;
        ld_req_tag_valid_o = 1'b0;
        ld_req_kill_o      = 1'b0;
        ld_req_size_o      = '0;
        ld_req_be_o        = '0;
        st_req_valid_o     = 1'b0;
        st_req_index_o     = '0;
        st_req_tag_o       = '0;
        st_req_tag_valid_o = 1'b0;
        st_req_kill_o      = 1'b0;
        st_req_size_o      = '0;
        st_req_be_o        = '0;
        st_req_wdata_o     = '0;
        if (issue_v) begin
            if (hd.we) begin
                st_req_valid_o = 1'b1;
                st_req_index_o = hd.addr[INDEX_W-1:0];
                st_req_size_o  = hd.size;
                st_req_be_o    = be;
                st_req_wdata_o = hd.wdata << {off, 3'b000};
            end else begin
                ld_req_valid_o = 1'b1;
                ld_req_index_o = hd.addr[INDEX_W-1:0];
                ld_req_size_o  = hd.size;
                ld_req_be_o    = be;
            end
        end
        if (state == ST_TAG) begin
            if (hd.we) begin
                st_req_tag_o       = hd.addr[ADDR_W-1:INDEX_W];
                st_req_tag_valid_o = !cpu_kill_i;
                st_req_kill_o      = cpu_kill_i;
            end else begin
                ld_req_tag_o       = hd.addr[ADDR_W-1:INDEX_W];
                ld_req_tag_valid_o = !cpu_kill_i;
                ld_req_kill_o      = cpu_kill_i;
            end
        end
    end
endmodule
